// File: rtl/copier_pkg.sv
// rtl/copier_pkg.sv - shared widths and engine state encoding for the block copier
package copier_pkg;
    localparam int COPIER_AW = 6;
    localparam int COPIER_DW = 32;
    localparam int COPIER_LW = 7;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FINISH
    } state_e;
endpackage

// File: rtl/copier_addr_gen.sv
// rtl/copier_addr_gen.sv - word pointer that loads base+offset and steps +/-1 modulo 2^AW
module copier_addr_gen #(
    parameter int AW = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic          step,
    input  logic          dec,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] offset,
    output logic [AW-1:0] ptr,
    output logic [AW-1:0] ptr_next
);
    logic [AW-1:0] ptr_q, ptr_d;

    // ptr_next lets the caller register the address it is about to use on the same edge
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = base + offset;
        end else if (step) begin
            ptr_d = dec ? ptr_q - AW'(1) : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr      = ptr_q;
    assign ptr_next = ptr_d;
endmodule

// File: rtl/copier_block_engine.sv
// rtl/copier_block_engine.sv - overlap-safe block copy sequencer driving the copier data memory
module copier_block_engine
    import copier_pkg::*;
#(
    parameter int AW = COPIER_AW,
    parameter int DW = COPIER_DW,
    parameter int LW = COPIER_LW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [LW-1:0] cmd_len,
    output logic          cpl_valid,
    output logic          busy,
    output logic [AW-1:0] aq,
    output logic          read,
    output logic [DW-1:0] wq,
    output logic          sel,
    input  logic [DW-1:0] rq,
    input  logic          done
);
    localparam logic [LW-1:0] DEPTH = LW'(1 << AW);

    state_e        state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          cpl_valid_q, cpl_valid_d;
    logic          sel_q, sel_d;
    logic          read_q, read_d;
    logic          dec_q, dec_d;
    logic [AW-1:0] aq_q, aq_d;
    logic [DW-1:0] data_q, data_d;
    logic [LW-1:0] rem_q, rem_d;

    logic [AW-1:0] diff, start_off;
    logic [LW-1:0] len_eff;
    logic          desc, accept, step;
    logic [AW-1:0] src_ptr, src_next, dst_ptr, dst_next;

    // Descend only when the destination starts inside the source block, so no source word
    // is overwritten before it has been read.
    always_comb begin
        diff      = cmd_dst - cmd_src;
        len_eff   = (cmd_len > DEPTH) ? DEPTH : cmd_len;
        desc      = (diff != '0) && ({{(LW-AW){1'b0}}, diff} < len_eff);
        start_off = desc ? AW'(len_eff - LW'(1)) : '0;
        accept    = (state_q == IDLE) && cmd_valid;
        step      = (state_q == WRITE) && done;
    end

    copier_addr_gen #(.AW(AW)) u_src_gen (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (accept),
        .step     (step),
        .dec      (dec_q),
        .base     (cmd_src),
        .offset   (start_off),
        .ptr      (src_ptr),
        .ptr_next (src_next)
    );

    copier_addr_gen #(.AW(AW)) u_dst_gen (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (accept),
        .step     (step),
        .dec      (dec_q),
        .base     (cmd_dst),
        .offset   (start_off),
        .ptr      (dst_ptr),
        .ptr_next (dst_next)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cpl_valid_d = cpl_valid_q;
        sel_d       = sel_q;
        read_d      = read_q;
        dec_d       = dec_q;
        aq_d        = aq_q;
        data_d      = data_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    dec_d       = desc;
                    rem_d       = len_eff;
                    if (len_eff == '0) begin
                        state_d     = FINISH;
                        cpl_valid_d = 1'b1;
                    end else begin
                        state_d = READ;
                        sel_d   = 1'b1;
                        read_d  = 1'b1;
                        aq_d    = src_next;
                    end
                end
            end
            READ: begin
                if (done) begin
                    state_d = WRITE;
                    data_d  = rq;
                    read_d  = 1'b0;
                    aq_d    = dst_next;
                end
            end
            WRITE: begin
                if (done) begin
                    rem_d  = rem_q - LW'(1);
                    read_d = 1'b1;
                    if (rem_q == LW'(1)) begin
                        state_d     = FINISH;
                        sel_d       = 1'b0;
                        cpl_valid_d = 1'b1;
                    end else begin
                        state_d = READ;
                        aq_d    = src_next;
                    end
                end
            end
            FINISH: begin
                state_d     = IDLE;
                cpl_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            cpl_valid_q <= 1'b0;
            sel_q       <= 1'b0;
            read_q      <= 1'b1;
            dec_q       <= 1'b0;
            aq_q        <= '0;
            data_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cpl_valid_q <= cpl_valid_d;
            sel_q       <= sel_d;
            read_q      <= read_d;
            dec_q       <= dec_d;
            aq_q        <= aq_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = ~cmd_ready_q;
    assign cpl_valid = cpl_valid_q;
    assign sel       = sel_q;
    assign read      = read_q;
    assign aq        = aq_q;
    assign wq        = data_q;
endmodule

// File: tb/tb_copier_block_engine.sv
// tb/tb_copier_block_engine.sv - directed self-checking bench for copier_block_engine
module tb_copier_block_engine;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready, cpl_valid, busy, read, sel, done;
    logic [5:0]  cmd_src = '0, cmd_dst = '0, aq;
    logic [6:0]  cmd_len = '0;
    logic [31:0] wq, rq;

    logic [31:0] mem [64];
    logic [31:0] img [64];
    logic        load_en = 1'b0;
    logic        select = 1'b0;
    int          rd_log[$];
    int          wr_log[$];
    int          total = 0;
    int          bad = 0;
    int          cyc;
    bit          sel_seen;

    always #5 clock = ~clock;

    copier_block_engine dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cpl_valid (cpl_valid),
        .busy      (busy),
        .aq        (aq),
        .read      (read),
        .wq        (wq),
        .sel       (sel),
        .rq        (rq),
        .done      (done)
    );

    // data memory model: registered select, done = select, combinational read
    assign done = select;
    assign rq   = mem[aq];
    always @(posedge clock) begin
        if (load_en) begin
            mem <= img;
            rd_log.delete();
            wr_log.delete();
        end else if (select) begin
            if (read) begin
                rd_log.push_back(int'(aq));
            end else begin
                mem[aq] <= wq;
                wr_log.push_back(int'(aq));
            end
        end
        select <= sel & ~done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge clock);
        load_en = 1'b1;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic run_copy(input int s, input int d, input int l, output int c, output bit seen);
        @(negedge clock);
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_src   = 6'(s);
        cmd_dst   = 6'(d);
        cmd_len   = 7'(l);
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        c    = 0;
        seen = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            if (sel) seen = 1'b1;
            if (cpl_valid) begin
                c = k;
                break;
            end
        end
        if (c == 0) check("cpl_timeout", 32'd0, 32'd1);
    endtask

    // memmove reference built from the pre-copy image
    task automatic check_mem(input string tag, input int s, input int d, input int n);
        logic [31:0] exp [64];
        for (int i = 0; i < 64; i++) exp[i] = img[i];
        for (int k = 0; k < n; k++) exp[(d + k) % 64] = img[(s + k) % 64];
        for (int i = 0; i < 64; i++) check($sformatf("%s_mem%0d", tag, i), mem[i], exp[i]);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) img[i] = 32'hA0 + 32'(i);
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel", {31'd0, sel}, 32'd0);
        check("rst_read", {31'd0, read}, 32'd1);
        check("rst_aq", {26'd0, aq}, 32'd0);
        check("rst_wq", wq, 32'd0);
        reset_n = 1'b1;

        // 1: plain ascending copy
        load_mem();
        run_copy(0, 32, 4, cyc, sel_seen);
        check("t1_cycles", 32'(cyc), 32'd17);
        check("t1_m32", mem[32], 32'hA0);
        check("t1_m35", mem[35], 32'hA3);
        check_mem("t1", 0, 32, 4);

        // 2: overlapping, dst above src -> descending
        load_mem();
        run_copy(10, 12, 5, cyc, sel_seen);
        check("t2_cycles", 32'(cyc), 32'd21);
        check("t2_first_wr", 32'(wr_log[0]), 32'd16);
        check("t2_first_rd", 32'(rd_log[0]), 32'd14);
        check("t2_m12", mem[12], 32'hAA);
        check("t2_m16", mem[16], 32'hAE);
        check_mem("t2", 10, 12, 5);

        // 3: source wraps 63 -> 0
        load_mem();
        run_copy(62, 5, 4, cyc, sel_seen);
        check("t3_rd_n", 32'(rd_log.size()), 32'd4);
        check("t3_rd0", 32'(rd_log[0]), 32'd62);
        check("t3_rd1", 32'(rd_log[1]), 32'd63);
        check("t3_rd2", 32'(rd_log[2]), 32'd0);
        check("t3_rd3", 32'(rd_log[3]), 32'd1);
        check("t3_wr0", 32'(wr_log[0]), 32'd5);
        check("t3_wr3", 32'(wr_log[3]), 32'd8);
        check("t3_m5", mem[5], 32'hDE);
        check("t3_m7", mem[7], 32'hA0);
        check_mem("t3", 62, 5, 4);

        // 4: zero length
        load_mem();
        run_copy(3, 9, 0, cyc, sel_seen);
        check("t4_cycles", 32'(cyc), 32'd1);
        check("t4_sel_seen", {31'd0, sel_seen}, 32'd0);
        check_mem("t4", 3, 9, 0);

        // 5: oversize length saturates to a full 64-word self copy
        load_mem();
        run_copy(5, 5, 100, cyc, sel_seen);
        check("t5_cycles", 32'(cyc), 32'd257);
        check("t5_wr_n", 32'(wr_log.size()), 32'd64);
        check_mem("t5", 5, 5, 64);

        // 6: reset during the write of word 2
        load_mem();
        @(negedge clock);
        cmd_src = 6'd0; cmd_dst = 6'd20; cmd_len = 7'd4; cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (7) @(negedge clock);
        check("t6_pre_sel", {31'd0, sel}, 32'd1);
        check("t6_pre_read", {31'd0, read}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("t6_sel", {31'd0, sel}, 32'd0);
        check("t6_read", {31'd0, read}, 32'd1);
        check("t6_ready", {31'd0, cmd_ready}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_aq", {26'd0, aq}, 32'd0);
        check("t6_wq", wq, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("t6_no_cpl", {31'd0, cpl_valid}, 32'd0);
        end
        reset_n = 1'b1;
        run_copy(3, 40, 1, cyc, sel_seen);
        check("t6_cycles", 32'(cyc), 32'd5);
        check("t6_m40", mem[40], 32'hA3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
